bidir_step_counter: RTL and testbench

- Responder end of the enable/forward/finish counter interface that the light-sequencer controller drives.
- An up/down step counter advances one step every PRESCALE enabled cycles in the commanded direction.
- On reaching the terminal value for that direction it returns a one-cycle finish pulse, then holds until the direction flips or enable drops.
- Feeds the display/colour logic through out and the at_max/at_min flags.

---
 rtl/bidir_step_pkg.sv | 15 +
 rtl/step_prescaler.sv | 37 +++
 rtl/bidir_step_counter.sv | 135 +++++++++++++
 tb/tb_bidir_step_counter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bidir_step_pkg.sv
// Shared types and constants for the bidirectional step counter.
package bidir_step_pkg;

  // Counter control states; encoding is fixed so external observers can decode it.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Latched direction values.
  localparam logic DirUp = 1'b1;
  localparam logic DirDn = 1'b0;

endpackage

// File: rtl/step_prescaler.sv
// Prescale counter: pulses tick once every PRESCALE cycles that run is held high.
// The count is cleared whenever run drops, so each RUN stretch starts from zero.
module step_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic tick
);

  localparam int unsigned PcntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PcntW-1:0] PcntLast = PcntW'(PRESCALE - 1);

  logic [PcntW-1:0] pcnt_q, pcnt_d;

  assign tick = run && (pcnt_q == PcntLast);

  // Advance while running, wrap on tick, otherwise park at zero.
  always_comb begin
    pcnt_d = '0;
    if (run && !tick) begin
      pcnt_d = pcnt_q + 1'b1;
    end
  end

  // Prescale count register with synchronous reset/restart.
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/bidir_step_counter.sv
// Up/down step counter responding to the light-sequencer enable/forward/finish handshake.
// Steps once per PRESCALE enabled cycles toward the terminal of the latched direction,
// pulses finish on arrival and holds until the direction flips or enable drops.
module bidir_step_counter
  import bidir_step_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 15,
  parameter int unsigned MIN_VAL  = 0,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             forward,
  output logic [WIDTH-1:0] out,
  output logic             finish,
  output logic             busy,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN_VAL);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dir_q, dir_d;
  logic             finish_q, finish_d;

  logic             flip;
  logic             tick;
  logic             presc_run;
  logic [WIDTH-1:0] term_cur;
  logic [WIDTH-1:0] term_new;
  logic [WIDTH-1:0] out_step;

  assign flip     = (forward != dir_q);
  assign term_cur = (dir_q == DirUp) ? MaxVal : MinVal;
  assign term_new = (forward == DirUp) ? MaxVal : MinVal;
  // RUN never holds out at its terminal, so this step cannot leave [MIN_VAL, MAX_VAL].
  assign out_step = (dir_q == DirUp) ? (out_q + 1'b1) : (out_q - 1'b1);

  // Prescaler only counts on cycles where a step could actually be taken.
  assign presc_run = (state_q == StRun) && enable && !flip && !clear;

  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .restart (clear),
    .run     (presc_run),
    .tick    (tick)
  );

  // State, count, direction and finish registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      out_q    <= MinVal;
      dir_q    <= DirUp;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
      finish_q <= finish_d;
    end
  end

  // Next-state: clear, then enable low, then direction flip, then prescaled step.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    dir_d    = dir_q;
    finish_d = 1'b0;
    if (clear) begin
      state_d = StIdle;
      out_d   = MinVal;
      dir_d   = forward;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            dir_d = forward;
            if (out_q == term_new) begin
              finish_d = 1'b1;
              state_d  = StDone;
            end else begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (!enable) begin
            state_d = StIdle;
          end else if (flip) begin
            dir_d = forward;
            if (out_q == term_new) begin
              finish_d = 1'b1;
              state_d  = StDone;
            end
          end else if (tick) begin
            out_d = out_step;
            if (out_step == term_cur) begin
              finish_d = 1'b1;
              state_d  = StDone;
            end
          end
        end
        StDone: begin
          if (!enable) begin
            state_d = StIdle;
          end else if (flip) begin
            dir_d   = forward;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs: registered count/finish, decoded busy and terminal flags.
  always_comb begin
    out    = out_q;
    finish = finish_q;
    busy   = (state_q == StRun);
    at_max = (out_q == MaxVal);
    at_min = (out_q == MinVal);
  end

endmodule

// File: tb/tb_bidir_step_counter.sv
// Bench for bidir_step_counter: two instances (PRESCALE 1 and 4) share stimulus and are
// compared every cycle against a step-counting reference model.
module tb_bidir_step_counter;

  localparam int MaxV = 15;
  localparam int MinV = 0;

  logic clk = 1'b0;
  logic reset, clear, enable, forward;
  logic [3:0] out1, out4;
  logic fin1, busy1, amax1, amin1;
  logic fin4, busy4, amax4, amin4;

  int total = 0;
  int bad   = 0;

  // Reference model state per instance: count, mode (0 idle, 1 run, 2 done),
  // enabled run cycles since last step, latched direction, finish pulse.
  int m_cnt  [2];
  int m_mode [2];
  int m_pc   [2];
  int m_dir  [2];
  bit m_fin  [2];
  int ps     [2] = '{1, 4};

  bidir_step_counter #(
    .WIDTH(4), .MAX_VAL(15), .MIN_VAL(0), .PRESCALE(1)
  ) u_p1 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .forward(forward),
    .out(out1), .finish(fin1), .busy(busy1), .at_max(amax1), .at_min(amin1)
  );

  bidir_step_counter #(
    .WIDTH(4), .MAX_VAL(15), .MIN_VAL(0), .PRESCALE(4)
  ) u_p4 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .forward(forward),
    .out(out4), .finish(fin4), .busy(busy4), .at_max(amax4), .at_min(amin4)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] observed(input int k);
    if (k == 0) return {out1, fin1, busy1, amax1, amin1};
    return {out4, fin4, busy4, amax4, amin4};
  endfunction

  function automatic logic [7:0] expected(input int k);
    logic [31:0] c;
    c = m_cnt[k];
    return {c[3:0], m_fin[k], m_mode[k] == 1, m_cnt[k] == MaxV, m_cnt[k] == MinV};
  endfunction

  function automatic int term_of(input int d);
    return (d != 0) ? MaxV : MinV;
  endfunction

  task automatic model_edge(input int k);
    m_fin[k] = 1'b0;
    if (reset) begin
      m_cnt[k] = MinV; m_mode[k] = 0; m_pc[k] = 0; m_dir[k] = 1;
    end else if (clear) begin
      m_cnt[k] = MinV; m_mode[k] = 0; m_pc[k] = 0; m_dir[k] = int'(forward);
    end else if (!enable) begin
      m_mode[k] = 0; m_pc[k] = 0;
    end else if (m_mode[k] == 0) begin
      m_dir[k] = int'(forward);
      m_pc[k]  = 0;
      if (m_cnt[k] == term_of(m_dir[k])) begin
        m_fin[k] = 1'b1; m_mode[k] = 2;
      end else begin
        m_mode[k] = 1;
      end
    end else if (int'(forward) != m_dir[k]) begin
      m_dir[k] = int'(forward);
      m_pc[k]  = 0;
      if (m_mode[k] == 1 && m_cnt[k] == term_of(m_dir[k])) begin
        m_fin[k] = 1'b1; m_mode[k] = 2;
      end else begin
        m_mode[k] = 1;
      end
    end else if (m_mode[k] == 1) begin
      m_pc[k] = m_pc[k] + 1;
      if (m_pc[k] == ps[k]) begin
        m_pc[k]  = 0;
        m_cnt[k] = m_cnt[k] + ((m_dir[k] != 0) ? 1 : -1);
        if (m_cnt[k] == term_of(m_dir[k])) begin
          m_fin[k] = 1'b1; m_mode[k] = 2;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; clear = 1'b0; enable = 1'b0; forward = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    total += 2;
    if (observed(0) !== expected(0)) begin
      bad++; $display("FAIL reset p1 got=%b exp=%b", observed(0), expected(0));
    end
    if (observed(1) !== expected(1)) begin
      bad++; $display("FAIL reset p4 got=%b exp=%b", observed(1), expected(1));
    end
    total++;
    if ({out1, fin1, busy1, amin1} !== 7'b0000_0_0_1) begin
      bad++; $display("FAIL reset_const got=%b exp=%b", {out1, fin1, busy1, amin1}, 7'b0000001);
    end
  endtask

  task automatic test_up_sweep();
    for (int i = 0; i <= 17; i++) begin
      enable = 1'b1; forward = 1'b1;
      cycle();
      total += 2;
      if (observed(0) !== expected(0)) begin
        bad++; $display("FAIL up_sweep p1 edge=%0d got=%b exp=%b", i, observed(0), expected(0));
      end
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL up_sweep p4 edge=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
      if (i == 14 || i == 15 || i == 16) begin
        total++;
        if ({out1, fin1, busy1} !== ((i == 14) ? 6'b1110_0_1 : (i == 15) ? 6'b1111_1_0 : 6'b1111_0_0)) begin
          bad++; $display("FAIL up_sweep_edge%0d got=%b", i, {out1, fin1, busy1});
        end
      end
    end
  endtask

  task automatic test_down_sweep();
    for (int i = 0; i <= 16; i++) begin
      enable = 1'b1; forward = 1'b0;
      cycle();
      total += 2;
      if (observed(0) !== expected(0)) begin
        bad++; $display("FAIL down_sweep p1 edge=%0d got=%b exp=%b", i, observed(0), expected(0));
      end
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL down_sweep p4 edge=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
      if (i == 0 || i == 15) begin
        total++;
        if ({out1, fin1} !== ((i == 0) ? 5'b1111_0 : 5'b0000_1)) begin
          bad++; $display("FAIL down_sweep_edge%0d got=%b", i, {out1, fin1});
        end
      end
    end
  endtask

  task automatic test_prescale();
    apply_reset();
    for (int i = 0; i <= 62; i++) begin
      enable = 1'b1; forward = 1'b1;
      cycle();
      total++;
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL prescale p4 edge=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
      if (i == 3 || i == 4 || i == 60) begin
        total++;
        if ({out4, fin4} !== ((i == 3) ? 5'b0000_0 : (i == 4) ? 5'b0001_0 : 5'b1111_1)) begin
          bad++; $display("FAIL prescale_edge%0d got=%b", i, {out4, fin4});
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      forward = 1'b1;
      enable  = !(i >= 8 && i < 11);
      cycle();
      total += 2;
      if (observed(0) !== expected(0)) begin
        bad++; $display("FAIL enable_drop p1 step=%0d got=%b exp=%b", i, observed(0), expected(0));
      end
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL enable_drop p4 step=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
      // Edges 8..10 idle, edge 11 re-enters RUN, next step at edge 12.
      if (i >= 8 && i <= 12) begin
        total++;
        if ({out1, fin1} !== ((i == 12) ? 5'b1000_0 : 5'b0111_0)) begin
          bad++; $display("FAIL enable_drop_hold%0d got=%b", i, {out1, fin1});
        end
      end
    end
  endtask

  task automatic test_already_terminal();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      enable = 1'b1; forward = 1'b0;
      cycle();
      total += 2;
      if (observed(0) !== expected(0)) begin
        bad++; $display("FAIL at_terminal p1 step=%0d got=%b exp=%b", i, observed(0), expected(0));
      end
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL at_terminal p4 step=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
      total++;
      if ({out1, fin1, busy1} !== ((i == 0) ? 6'b0000_1_0 : 6'b0000_0_0)) begin
        bad++; $display("FAIL at_terminal_const%0d got=%b", i, {out1, fin1, busy1});
      end
    end
  endtask

  task automatic test_clear_on_step();
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      enable  = 1'b1; forward = 1'b1;
      clear   = (i == 10);
      reset   = (i >= 12);
      cycle();
      total += 2;
      if (observed(0) !== expected(0)) begin
        bad++; $display("FAIL clear_step p1 step=%0d got=%b exp=%b", i, observed(0), expected(0));
      end
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL clear_step p4 step=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
      if (i == 9 || i == 10 || i >= 12) begin
        total++;
        if ({out1, fin1, busy1} !== ((i == 9) ? 6'b1001_0_1 : 6'b0000_0_0)) begin
          bad++; $display("FAIL clear_step_const%0d got=%b", i, {out1, fin1, busy1});
        end
      end
    end
    reset = 1'b0; clear = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      reset  = ($urandom_range(0, 79) == 0);
      clear  = ($urandom_range(0, 59) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) forward = ~forward;
      cycle();
      total += 2;
      if (observed(0) !== expected(0)) begin
        bad++; $display("FAIL random p1 step=%0d got=%b exp=%b", i, observed(0), expected(0));
      end
      if (observed(1) !== expected(1)) begin
        bad++; $display("FAIL random p4 step=%0d got=%b exp=%b", i, observed(1), expected(1));
      end
    end
    reset = 1'b0; clear = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = MinV; m_mode[k] = 0; m_pc[k] = 0; m_dir[k] = 1; m_fin[k] = 1'b0;
    end
    reset = 1'b1; clear = 1'b0; enable = 1'b0; forward = 1'b1;
    test_reset();
    test_up_sweep();
    test_down_sweep();
    test_prescale();
    test_enable_drop();
    test_already_terminal();
    test_clear_on_step();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
